id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register for the pipelined LEGv8 core; sits directly downstream of regfile.
- Captures regfile read data (rd1/rd2) plus decoded fields each cycle and presents them to the execute stage.
- Supports stall (hold), flush (bubble insertion), and a same-cycle writeback bypass, so a value written by WB in the same cycle it is read is never lost.
- Also refreshes a held (stalled) operand when WB writes its source register.

Parameters:
- N, 64, datapath width (register data, PC, immediate).
- CTRL_W, 11, width of the opaque control bundle passed from decode to execute.
- ZR, 31, index of XZR; always reads as zero, never bypassed.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold the current contents; do not load ID inputs.
- flush  input  1  replace the contents with a bubble on the next edge.
- id_valid  input  1  the ID stage holds a real instruction.
- id_pc  input  N  PC of the ID instruction.
- id_ra1  input  5  regfile read address 1 (same value driven to regfile ra1).
- id_ra2  input  5  regfile read address 2.
- id_rd1  input  N  regfile rd1.
- id_rd2  input  N  regfile rd2.
- id_imm  input  N  sign-extended immediate.
- id_wa  input  5  destination register.
- id_ctrl  input  CTRL_W  decoded control bundle.
- wb_we  input  1  WB write enable (same signal as regfile we3).
- wb_wa  input  5  WB write address (regfile wa3).
- wb_wd  input  N  WB write data (regfile wd3).
- ex_valid  output  1  the EX entry is a real instruction.
- ex_pc  output  N  latched PC.
- ex_ra1  output  5  latched source address 1.
- ex_ra2  output  5  latched source address 2.
- ex_rd1  output  N  latched operand 1.
- ex_rd2  output  N  latched operand 2.
- ex_imm  output  N  latched immediate.
- ex_wa  output  5  latched destination register.
- ex_ctrl  output  CTRL_W  latched control; all-zero in a bubble.

Behaviour:
- All outputs are registers; there is no combinational path from any input to any output. Latency is 1 cycle.
- Per-edge priority: reset > flush > stall > load.
- reset=1 drives every output to 0, including ex_valid=0 and ex_ctrl=0.
- flush=1 (with or without stall) loads a bubble:
  - ex_valid=0, ex_ctrl=0, ex_wa=ZR.
  - All other outputs are 0.
- Load (stall=0, flush=0): all ID inputs are latched, with operand selection per source k in {1,2}:
  - id_rak==ZR: ex_rdk=0, regardless of id_rdk and of any WB write.
  - wb_we=1 and wb_wa==id_rak: ex_rdk=wb_wd (same-cycle bypass).
  - Otherwise: ex_rdk=id_rdk.
- Stall (stall=1, flush=0): all fields hold, except the operand refresh:
  - Condition: ex_valid=1, wb_we=1, wb_wa==ex_rak, and ex_rak!=ZR.
  - Effect: ex_rdk<=wb_wd.
  - This applies to rd1 and rd2 independently. If ra1==ra2, both update.
- id_valid=0 on a load produces ex_valid=0, but the other fields are still latched. Consumers gate on ex_valid; ex_ctrl is not forced to 0 in this case.
- wb_we=1 with wb_wa==ZR never affects any operand.
- A stall that spans many cycles keeps applying the refresh rule every cycle. The last WB write to a matching register wins.
- Reset asserted mid-stall or mid-flush: reset wins, and the block is fully cleared on that edge.
- Deasserting reset: the first edge with reset=0 performs a normal load, flush, or stall.

Test Plan:
- Reset: reset=1 for 2 cycles with all inputs non-zero -> every output reads 0, ex_valid=0.
- Plain load: id_ra1=3, id_rd1=64'h1111, id_ra2=4, id_rd2=64'h2222, id_imm=64'hFFFF_FFFF_FFFF_FFF8, id_valid=1, wb_we=0 -> after 1 edge, ex_rd1=64'h1111, ex_rd2=64'h2222, ex_imm=-8, ex_valid=1.
- Same-cycle bypass:
  - Setup: id_ra1=5, id_rd1=64'hDEAD (stale), wb_we=1, wb_wa=5, wb_wd=64'hBEEF -> ex_rd1=64'hBEEF.
  - Same setup with wb_wa=6 -> ex_rd1=64'hDEAD.
- XZR: id_ra1=31, id_ra2=31, id_rd1=id_rd2=64'h5, wb_we=1, wb_wa=31, wb_wd=64'h7 -> ex_rd1=ex_rd2=0.
- Stall with refresh:
  - Load ra2=9, rd2=64'h10.
  - Then stall=1 for 3 cycles, changing all ID inputs each cycle.
  - In the 2nd stall cycle drive wb_we=1, wb_wa=9, wb_wd=64'h99 -> all fields hold their loaded values except ex_rd2, which becomes 64'h99 after that edge and stays 64'h99.
- Flush priority:
  - stall=1 and flush=1 together -> ex_valid=0, ex_ctrl=0, ex_wa=31.
  - Next cycle stall=0, flush=0 with a valid ID -> normal load.
  - reset=1 together with flush=0 and stall=1 mid-sequence -> all outputs 0.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register for the pipelined LEGv8 core.
// Supports stall, flush, a same-cycle WB bypass on load, and WB refresh of held operands.
module id_ex_reg #(
  parameter int unsigned N      = 64,
  parameter int unsigned CTRL_W = 11,
  parameter int unsigned ZR     = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [N-1:0]      id_pc,
  input  logic [4:0]        id_ra1,
  input  logic [4:0]        id_ra2,
  input  logic [N-1:0]      id_rd1,
  input  logic [N-1:0]      id_rd2,
  input  logic [N-1:0]      id_imm,
  input  logic [4:0]        id_wa,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_we,
  input  logic [4:0]        wb_wa,
  input  logic [N-1:0]      wb_wd,
  output logic              ex_valid,
  output logic [N-1:0]      ex_pc,
  output logic [4:0]        ex_ra1,
  output logic [4:0]        ex_ra2,
  output logic [N-1:0]      ex_rd1,
  output logic [N-1:0]      ex_rd2,
  output logic [N-1:0]      ex_imm,
  output logic [4:0]        ex_wa,
  output logic [CTRL_W-1:0] ex_ctrl
);

  localparam logic [4:0] ZR_A = 5'(ZR);

  logic              valid_q, valid_d;
  logic [N-1:0]      pc_q, pc_d;
  logic [4:0]        ra1_q, ra1_d;
  logic [4:0]        ra2_q, ra2_d;
  logic [N-1:0]      rd1_q, rd1_d;
  logic [N-1:0]      rd2_q, rd2_d;
  logic [N-1:0]      imm_q, imm_d;
  logic [4:0]        wa_q, wa_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // XZR reads as zero and is never bypassed; otherwise a same-cycle WB write wins.
  function automatic logic [N-1:0] sel_operand(input logic [4:0] ra, input logic [N-1:0] rd);
    if (ra == ZR_A)                  return '0;
    else if (wb_we && wb_wa == ra)   return wb_wd;
    else                             return rd;
  endfunction

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    wa_d    = wa_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      ra1_d   = '0;
      ra2_d   = '0;
      rd1_d   = '0;
      rd2_d   = '0;
      imm_d   = '0;
      wa_d    = ZR_A;
      ctrl_d  = '0;
    end else if (!stall) begin
      valid_d = id_valid;
      pc_d    = id_pc;
      ra1_d   = id_ra1;
      ra2_d   = id_ra2;
      rd1_d   = sel_operand(id_ra1, id_rd1);
      rd2_d   = sel_operand(id_ra2, id_rd2);
      imm_d   = id_imm;
      wa_d    = id_wa;
      ctrl_d  = id_ctrl;
    end else begin
      // Held operands track WB writes so the entry is current when the stall releases.
      if (valid_q && wb_we && wb_wa == ra1_q && ra1_q != ZR_A) rd1_d = wb_wd;
      if (valid_q && wb_we && wb_wa == ra2_q && ra2_q != ZR_A) rd2_d = wb_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      wa_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      wa_q    <= wa_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign ex_valid = valid_q;
  assign ex_pc    = pc_q;
  assign ex_ra1   = ra1_q;
  assign ex_ra2   = ra2_q;
  assign ex_rd1   = rd1_q;
  assign ex_rd2   = rd2_q;
  assign ex_imm   = imm_q;
  assign ex_wa    = wa_q;
  assign ex_ctrl  = ctrl_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: vector table plus hand-written stall/reset sequences, scoreboard-checked.
module tb_id_ex_reg;

  typedef struct {
    logic        rst, stall, flush, vld;
    logic [63:0] pc;
    logic [4:0]  ra1, ra2;
    logic [63:0] rd1, rd2, imm;
    logic [4:0]  wa;
    logic [10:0] ctrl;
    logic        we;
    logic [4:0]  wwa;
    logic [63:0] wwd;
  } in_t;

  typedef struct {
    logic        vld;
    logic [63:0] pc;
    logic [4:0]  ra1, ra2;
    logic [63:0] rd1, rd2, imm;
    logic [4:0]  wa;
    logic [10:0] ctrl;
  } out_t;

  typedef struct {
    string name;
    in_t   i;
    out_t  e;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid, wb_we;
  logic [63:0] id_pc, id_rd1, id_rd2, id_imm, wb_wd;
  logic [4:0]  id_ra1, id_ra2, id_wa, wb_wa;
  logic [10:0] id_ctrl;
  logic        ex_valid;
  logic [63:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_ra1, ex_ra2, ex_wa;
  logic [10:0] ex_ctrl;

  int   n_vec = 0;
  int   n_bad = 0;
  out_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  id_ex_reg #(.N(64), .CTRL_W(11), .ZR(31)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_ra1(id_ra1), .id_ra2(id_ra2), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_wa(id_wa), .id_ctrl(id_ctrl),
    .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ra1(ex_ra1), .ex_ra2(ex_ra2),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm), .ex_wa(ex_wa), .ex_ctrl(ex_ctrl)
  );

  function automatic in_t mi(logic rst, logic stl, logic fl, logic vld, logic [63:0] pc,
                             logic [4:0] ra1, logic [4:0] ra2, logic [63:0] rd1, logic [63:0] rd2,
                             logic [63:0] imm, logic [4:0] wa, logic [10:0] ctrl,
                             logic we, logic [4:0] wwa, logic [63:0] wwd);
    in_t r;
    r.rst = rst; r.stall = stl; r.flush = fl; r.vld = vld; r.pc = pc;
    r.ra1 = ra1; r.ra2 = ra2; r.rd1 = rd1; r.rd2 = rd2; r.imm = imm;
    r.wa = wa; r.ctrl = ctrl; r.we = we; r.wwa = wwa; r.wwd = wwd;
    return r;
  endfunction

  function automatic out_t mo(logic vld, logic [63:0] pc, logic [4:0] ra1, logic [4:0] ra2,
                              logic [63:0] rd1, logic [63:0] rd2, logic [63:0] imm,
                              logic [4:0] wa, logic [10:0] ctrl);
    out_t r;
    r.vld = vld; r.pc = pc; r.ra1 = ra1; r.ra2 = ra2; r.rd1 = rd1; r.rd2 = rd2;
    r.imm = imm; r.wa = wa; r.ctrl = ctrl;
    return r;
  endfunction

  function automatic out_t zero_out();
    return mo(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);
  endfunction

  function automatic out_t bubble();
    return mo(1'b0, '0, '0, '0, '0, '0, '0, 5'd31, '0);
  endfunction

  task automatic check(input string name);
    out_t e;
    if (sb.size() == 0) begin
      n_vec++; n_bad++;
      $display("FAIL %s: scoreboard empty, no expected result available", name);
      return;
    end
    e = sb.pop_front();
    n_vec++;
    if ({ex_valid, ex_pc, ex_ra1, ex_ra2, ex_rd1, ex_rd2, ex_imm, ex_wa, ex_ctrl} !==
        {e.vld, e.pc, e.ra1, e.ra2, e.rd1, e.rd2, e.imm, e.wa, e.ctrl}) begin
      n_bad++;
      $display("FAIL %s: got v=%b pc=%h ra=%0d/%0d rd1=%h rd2=%h imm=%h wa=%0d ctrl=%h; exp v=%b pc=%h ra=%0d/%0d rd1=%h rd2=%h imm=%h wa=%0d ctrl=%h",
               name, ex_valid, ex_pc, ex_ra1, ex_ra2, ex_rd1, ex_rd2, ex_imm, ex_wa, ex_ctrl,
               e.vld, e.pc, e.ra1, e.ra2, e.rd1, e.rd2, e.imm, e.wa, e.ctrl);
    end
  endtask

  task automatic apply(input string name, input in_t i, input out_t e);
    @(negedge clk);
    reset = i.rst; stall = i.stall; flush = i.flush; id_valid = i.vld; id_pc = i.pc;
    id_ra1 = i.ra1; id_ra2 = i.ra2; id_rd1 = i.rd1; id_rd2 = i.rd2; id_imm = i.imm;
    id_wa = i.wa; id_ctrl = i.ctrl; wb_we = i.we; wb_wa = i.wwa; wb_wd = i.wwd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    out_t l;
    reset = 1'b1; stall = 1'b0; flush = 1'b0; id_valid = 1'b0; id_pc = '0;
    id_ra1 = '0; id_ra2 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
    id_wa = '0; id_ctrl = '0; wb_we = 1'b0; wb_wa = '0; wb_wd = '0;

    tbl.push_back('{"reset1", mi(1,0,0,1, 64'h100, 1, 2, 64'hAAAA, 64'hBBBB, 64'hCCCC, 3, 11'h7FF, 1, 1, 64'h1234),
                   zero_out()});
    tbl.push_back('{"reset2", mi(1,1,1,1, 64'h104, 5, 6, 64'h5555, 64'h6666, 64'h7777, 8, 11'h555, 1, 5, 64'h4321),
                   zero_out()});
    tbl.push_back('{"load", mi(0,0,0,1, 64'h200, 3, 4, 64'h1111, 64'h2222, 64'hFFFF_FFFF_FFFF_FFF8, 7, 11'h155, 0, 3, 64'h9),
                   mo(1, 64'h200, 3, 4, 64'h1111, 64'h2222, 64'hFFFF_FFFF_FFFF_FFF8, 7, 11'h155)});
    tbl.push_back('{"bypass_rd1", mi(0,0,0,1, 64'h204, 5, 4, 64'hDEAD, 64'h2222, 64'h4, 8, 11'h2AA, 1, 5, 64'hBEEF),
                   mo(1, 64'h204, 5, 4, 64'hBEEF, 64'h2222, 64'h4, 8, 11'h2AA)});
    tbl.push_back('{"no_bypass", mi(0,0,0,1, 64'h208, 5, 4, 64'hDEAD, 64'h2222, 64'h4, 8, 11'h2AA, 1, 6, 64'hBEEF),
                   mo(1, 64'h208, 5, 4, 64'hDEAD, 64'h2222, 64'h4, 8, 11'h2AA)});
    tbl.push_back('{"bypass_rd2", mi(0,0,0,1, 64'h20C, 2, 6, 64'h22, 64'h66, 64'h8, 9, 11'h011, 1, 6, 64'hABC),
                   mo(1, 64'h20C, 2, 6, 64'h22, 64'hABC, 64'h8, 9, 11'h011)});
    tbl.push_back('{"bypass_both", mi(0,0,0,1, 64'h210, 10, 10, 64'h1, 64'h1, 64'h0, 11, 11'h022, 1, 10, 64'h77),
                   mo(1, 64'h210, 10, 10, 64'h77, 64'h77, 64'h0, 11, 11'h022)});
    tbl.push_back('{"xzr", mi(0,0,0,1, 64'h214, 31, 31, 64'h5, 64'h5, 64'h3, 12, 11'h033, 1, 31, 64'h7),
                   mo(1, 64'h214, 31, 31, 64'h0, 64'h0, 64'h3, 12, 11'h033)});
    tbl.push_back('{"invalid_load", mi(0,0,0,0, 64'h300, 1, 2, 64'hA, 64'hB, 64'h5, 4, 11'h3FF, 0, 1, 64'hF),
                   mo(0, 64'h300, 1, 2, 64'hA, 64'hB, 64'h5, 4, 11'h3FF)});
    tbl.push_back('{"flush_stall", mi(0,1,1,1, 64'h304, 7, 8, 64'h70, 64'h80, 64'h6, 9, 11'h444, 1, 7, 64'h1),
                   bubble()});
    tbl.push_back('{"load_after_flush", mi(0,0,0,1, 64'h400, 12, 13, 64'hC, 64'hD, 64'h10, 14, 11'h0F0, 1, 20, 64'hEE),
                   mo(1, 64'h400, 12, 13, 64'hC, 64'hD, 64'h10, 14, 11'h0F0)});
    tbl.push_back('{"flush_only", mi(0,0,1,1, 64'h404, 1, 1, 64'h1, 64'h1, 64'h1, 1, 11'h001, 0, 0, 64'h0),
                   bubble()});

    for (int k = 0; k < tbl.size(); k++) apply(tbl[k].name, tbl[k].i, tbl[k].e);

    // Stall spanning several cycles with WB refresh; last write wins.
    l = mo(1, 64'h500, 3, 9, 64'h30, 64'h10, 64'h1, 15, 11'h123);
    apply("stall_base", mi(0,0,0,1, 64'h500, 3, 9, 64'h30, 64'h10, 64'h1, 15, 11'h123, 0, 0, 64'h0), l);
    apply("stall1", mi(0,1,0,1, 64'h600, 9, 3, 64'h61, 64'h62, 64'h63, 16, 11'h600, 0, 9, 64'h55), l);
    l.rd2 = 64'h99;
    apply("stall2_refresh", mi(0,1,0,0, 64'h700, 4, 5, 64'h71, 64'h72, 64'h73, 17, 11'h700, 1, 9, 64'h99), l);
    apply("stall3_hold", mi(0,1,0,1, 64'h800, 6, 7, 64'h81, 64'h82, 64'h83, 18, 11'h080, 0, 3, 64'h44), l);
    l.rd1 = 64'h33;
    apply("stall_refresh_rd1", mi(0,1,0,1, 64'h900, 8, 2, 64'h91, 64'h92, 64'h93, 19, 11'h090, 1, 3, 64'h33), l);
    l.rd2 = 64'hAA;
    apply("stall_last_wins", mi(0,1,0,1, 64'hA00, 1, 2, 64'hA1, 64'hA2, 64'hA3, 20, 11'h0A0, 1, 9, 64'hAA), l);
    apply("stall_wb_xzr", mi(0,1,0,1, 64'hB00, 31, 31, 64'hB1, 64'hB2, 64'hB3, 21, 11'h0B0, 1, 31, 64'hBB), l);
    apply("reset_mid_stall", mi(1,1,0,1, 64'hC00, 3, 9, 64'hC1, 64'hC2, 64'hC3, 22, 11'h0C0, 1, 9, 64'hCC),
          zero_out());
    apply("load_after_reset", mi(0,0,0,1, 64'hD00, 31, 5, 64'hD1, 64'hD2, 64'hD3, 23, 11'h0D0, 0, 5, 64'hDD),
          mo(1, 64'hD00, 31, 5, 64'h0, 64'hD2, 64'hD3, 23, 11'h0D0));

    // Held operand at XZR is never refreshed, and invalid entries are never refreshed.
    l = mo(1, 64'hD00, 31, 5, 64'h0, 64'hD2, 64'hD3, 23, 11'h0D0);
    apply("stall_ex_xzr", mi(0,1,0,1, 64'hE00, 2, 2, 64'hE1, 64'hE2, 64'hE3, 24, 11'h0E0, 1, 31, 64'h7), l);
    l = mo(0, 64'hF00, 5, 6, 64'h50, 64'h60, 64'h2, 25, 11'h0F1);
    apply("invalid_base", mi(0,0,0,0, 64'hF00, 5, 6, 64'h50, 64'h60, 64'h2, 25, 11'h0F1, 0, 0, 64'h0), l);
    apply("stall_invalid_no_refresh", mi(0,1,0,1, 64'hF04, 1, 2, 64'h1, 64'h2, 64'h3, 26, 11'h001, 1, 5, 64'h5A), l);
    apply("reset_mid_flush", mi(1,0,1,1, 64'hF08, 1, 2, 64'h1, 64'h2, 64'h3, 27, 11'h002, 0, 0, 64'h0),
          zero_out());

    if (sb.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
